fft_bitrev_reorder: RTL and testbench

- Output-side reorder buffer for the radix-2 DIF FFT pipeline.
- Accepts one complex sample per valid cycle in bit-reversed index order, exactly as the final butterfly stage emits it.
- Uses a ping-pong buffer to stream each complete N-point frame out in natural order (bin 0 to N-1).
- Sits between the last FFT stage and downstream spectral consumers. It is the read-side counterpart of the stage pipeline that writes bit-reversed frames.

---
 rtl/fft_pkg.sv | 39 +++
 rtl/sdp_ram.sv | 33 +++
 rtl/fft_bitrev_reorder.sv | 204 ++++++++++++++++++++
 tb/tb_fft_bitrev_reorder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT output reorder path.
package fft_pkg;

  // Widest frame index the bit-reverse helper supports.
  localparam int MAX_LOG2N = 16;

  // Component width of the final FFT stage output.
  localparam int SAMPLE_WIDTH = 19;

  // One complex sample as exchanged between FFT blocks.
  typedef struct packed {
    logic signed [SAMPLE_WIDTH-1:0] re;
    logic signed [SAMPLE_WIDTH-1:0] im;
  } cplx_t;

  typedef enum logic {
    WR_SYNC = 1'b0,
    WR_FILL = 1'b1
  } wr_state_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RUN  = 1'b1
  } rd_state_t;

  // Mirror the low log2n bits of idx; bits at or above log2n come back as zero.
  function automatic logic [MAX_LOG2N-1:0] bit_reverse(input logic [MAX_LOG2N-1:0] idx,
                                                       input int log2n);
    logic [MAX_LOG2N-1:0] rev;
    rev = '0;
    for (int b = 0; b < MAX_LOG2N; b++) begin
      if (b < log2n) begin
        rev[4'(b)] = idx[4'(log2n - 1 - b)];
      end
    end
    return rev;
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
module sdp_ram #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 38
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port; contents are intentionally never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port; holds its last word while rd_en is low.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: bit-reversed input frames out in natural bin order.
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int WIDTH = 19,
  parameter int LOG2N = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_en,
  input  logic                    i_valid,
  input  logic                    i_sof,
  input  logic signed [WIDTH-1:0] i_real,
  input  logic signed [WIDTH-1:0] i_imag,
  output logic                    o_valid,
  output logic                    o_sof,
  output logic                    o_eof,
  output logic signed [WIDTH-1:0] o_real,
  output logic signed [WIDTH-1:0] o_imag,
  output logic                    o_frame_err
);

  localparam int ADDR_WIDTH = LOG2N + 1;
  localparam logic [LOG2N-1:0] LAST_IDX = {LOG2N{1'b1}};

  // Writer state
  wr_state_t        wr_state_reg;
  logic [LOG2N-1:0] wr_cnt_reg;
  logic             wr_bank_reg;
  logic             frame_err_reg;

  // Bank ownership: set by the writer on frame completion, cleared by the reader.
  logic [1:0]       full_reg;
  logic [1:0]       full_next;

  // Reader state
  rd_state_t        rd_state_reg, rd_state_next;
  logic [LOG2N-1:0] rd_cnt_reg, rd_cnt_next;
  logic             rd_bank_reg, rd_bank_next;
  logic             rd_issue;
  logic             rd_done;

  // Metadata travelling alongside the registered RAM read.
  logic             s1_valid_reg, s1_sof_reg, s1_eof_reg;

  // Writer datapath decode
  logic             wr_accept;
  logic             wr_restart;
  logic             wr_last;
  logic             wr_en;
  logic [LOG2N-1:0] wr_idx;

  logic [2*WIDTH-1:0] ram_rd_data;

  // Decide whether this sample is stored, where, and whether it ends or restarts a frame.
  always_comb begin
    wr_accept  = 1'b0;
    wr_restart = 1'b0;
    if (i_valid) begin
      if (wr_state_reg == WR_SYNC) begin
        wr_accept = i_sof;
      end else begin
        wr_accept  = 1'b1;
        wr_restart = i_sof && (wr_cnt_reg != '0);
      end
    end
    wr_en   = clk_en && wr_accept;
    // Any accepted i_sof is sample 0 of a frame, and bitrev(0) is 0.
    wr_idx  = i_sof ? '0 : LOG2N'(bit_reverse(MAX_LOG2N'(wr_cnt_reg), LOG2N));
    wr_last = wr_accept && !wr_restart && (wr_cnt_reg == LAST_IDX);
  end

  // Writer FSM, sample counter, bank pointer and frame-error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_reg  <= WR_SYNC;
      wr_cnt_reg    <= '0;
      wr_bank_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
    end else if (clk_en) begin
      frame_err_reg <= wr_accept && wr_restart;
      if (wr_accept) begin
        wr_state_reg <= WR_FILL;
        if (wr_restart) begin
          // Partial frame is abandoned; this sample already went to index 0.
          wr_cnt_reg <= LOG2N'(1);
        end else if (wr_last) begin
          wr_cnt_reg  <= '0;
          wr_bank_reg <= !wr_bank_reg;
        end else begin
          wr_cnt_reg <= wr_cnt_reg + 1'b1;
        end
      end
    end
  end

  // Reader next-state: pick the oldest full bank, sweep it, chain into the other if ready.
  always_comb begin
    rd_state_next = rd_state_reg;
    rd_cnt_next   = rd_cnt_reg;
    rd_bank_next  = rd_bank_reg;
    rd_issue      = 1'b0;
    rd_done       = 1'b0;
    case (rd_state_reg)
      RD_IDLE: begin
        if (|full_reg) begin
          rd_state_next = RD_RUN;
          rd_cnt_next   = '0;
          // With both banks full the writer has wrapped back onto the older one.
          rd_bank_next  = (&full_reg) ? wr_bank_reg : full_reg[1];
        end
      end
      RD_RUN: begin
        rd_issue = 1'b1;
        if (rd_cnt_reg == LAST_IDX) begin
          rd_done     = 1'b1;
          rd_cnt_next = '0;
          if (full_reg[!rd_bank_reg]) begin
            rd_bank_next = !rd_bank_reg;
          end else begin
            rd_state_next = RD_IDLE;
          end
        end else begin
          rd_cnt_next = rd_cnt_reg + 1'b1;
        end
      end
      default: rd_state_next = RD_IDLE;
    endcase
  end

  // Bank full flags: reader release first, then writer completion (never the same bank).
  always_comb begin
    full_next = full_reg;
    if (rd_done) begin
      full_next[rd_bank_reg] = 1'b0;
    end
    if (wr_accept && wr_last) begin
      full_next[wr_bank_reg] = 1'b1;
    end
  end

  // Reader state register and bank flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_reg <= RD_IDLE;
      rd_cnt_reg   <= '0;
      rd_bank_reg  <= 1'b0;
      full_reg     <= 2'b00;
    end else if (clk_en) begin
      rd_state_reg <= rd_state_next;
      rd_cnt_reg   <= rd_cnt_next;
      rd_bank_reg  <= rd_bank_next;
      full_reg     <= full_next;
    end
  end

  sdp_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (2 * WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr ({wr_bank_reg, wr_idx}),
    .wr_data ({i_real, i_imag}),
    .rd_en   (clk_en && rd_issue),
    .rd_addr ({rd_bank_reg, rd_cnt_reg}),
    .rd_data (ram_rd_data)
  );

  // Frame markers delayed to line up with the registered RAM output.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_sof_reg   <= 1'b0;
      s1_eof_reg   <= 1'b0;
    end else if (clk_en) begin
      s1_valid_reg <= rd_issue;
      s1_sof_reg   <= rd_issue && (rd_cnt_reg == '0);
      s1_eof_reg   <= rd_done;
    end
  end

  // Output register; data holds its last value between frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_sof   <= 1'b0;
      o_eof   <= 1'b0;
      o_real  <= '0;
      o_imag  <= '0;
    end else if (clk_en) begin
      o_valid <= s1_valid_reg;
      o_sof   <= s1_sof_reg;
      o_eof   <= s1_eof_reg;
      if (s1_valid_reg) begin
        o_real <= ram_rd_data[2*WIDTH-1:WIDTH];
        o_imag <= ram_rd_data[WIDTH-1:0];
      end
    end
  end

  assign o_frame_err = frame_err_reg;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for the FFT bit-reverse reorder buffer at N = 8.
module tb_fft_bitrev_reorder;

  localparam int W  = 19;
  localparam int LG = 3;
  localparam int N  = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic                clk_en;
  logic                i_valid;
  logic                i_sof;
  logic signed [W-1:0] i_real;
  logic signed [W-1:0] i_imag;
  logic                o_valid;
  logic                o_sof;
  logic                o_eof;
  logic signed [W-1:0] o_real;
  logic signed [W-1:0] o_imag;
  logic                o_frame_err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int re;
    int im;
    bit sof;
    bit eof;
    int ecnt;
  } rec_t;

  rec_t outq[$];
  int   ecnt         = 0;
  bit   en_q         = 1'b0;
  int   err_cnt      = 0;
  int   last_wr_ecnt = 0;
  int   gap_tbl [8]  = '{0, 2, 1, 0, 3, 0, 1, 0};

  always #5 clk = ~clk;

  fft_bitrev_reorder #(
    .WIDTH (W),
    .LOG2N (LG)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clk_en      (clk_en),
    .i_valid     (i_valid),
    .i_sof       (i_sof),
    .i_real      (i_real),
    .i_imag      (i_imag),
    .o_valid     (o_valid),
    .o_sof       (o_sof),
    .o_eof       (o_eof),
    .o_real      (o_real),
    .o_imag      (o_imag),
    .o_frame_err (o_frame_err)
  );

  // Count enabled edges and remember whether the last edge was enabled.
  always @(posedge clk) begin
    en_q = clk_en;
    if (clk_en) ecnt++;
  end

  // Capture one record per enabled output transaction.
  always @(negedge clk) begin
    rec_t r;
    if (en_q && o_valid) begin
      r.re   = int'(o_real);
      r.im   = int'(o_imag);
      r.sof  = o_sof;
      r.eof  = o_eof;
      r.ecnt = ecnt;
      outq.push_back(r);
      $display("out n=%0d re=%0d im=%0d sof=%0b eof=%0b edge=%0d",
               outq.size() - 1, r.re, r.im, r.sof, r.eof, r.ecnt);
    end
    if (en_q && o_frame_err) begin
      err_cnt++;
      $display("frame_err pulse edge=%0d", ecnt);
    end
  end

  task automatic check_value(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int tb_bitrev(input int j);
    logic [2:0] v;
    v = j[2:0];
    return int'({v[0], v[1], v[2]});
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit sof, input int re, input int im);
    i_valid = 1'b1;
    i_sof   = sof;
    i_real  = W'(re);
    i_imag  = W'(im);
    step();
    i_valid = 1'b0;
    i_sof   = 1'b0;
    last_wr_ecnt = ecnt;
    $display("in  sof=%0b re=%0d im=%0d edge=%0d", sof, re, im, ecnt);
  endtask

  // Input j carries bitrev(j) so that natural bin k must read back as (k, -k).
  task automatic send_frame(input bit use_gaps);
    for (int j = 0; j < N; j++) begin
      send(j == 0, tb_bitrev(j), -tb_bitrev(j));
      if (use_gaps) repeat (gap_tbl[j]) step();
    end
  endtask

  task automatic wait_outputs(input int n, input int budget);
    int k = 0;
    while (outq.size() < n && k < budget) begin
      step();
      k++;
    end
    if (outq.size() < n) check_value("wait_timeout", outq.size(), n);
  endtask

  task automatic check_frames(input string tag, input int n);
    check_value({tag, "_count"}, outq.size(), n);
    for (int i = 0; i < outq.size() && i < n; i++) begin
      check_value({tag, "_re"},  outq[i].re, i % N);
      check_value({tag, "_im"},  outq[i].im, -(i % N));
      check_value({tag, "_sof"}, int'(outq[i].sof), int'((i % N) == 0));
      check_value({tag, "_eof"}, int'(outq[i].eof), int'((i % N) == N - 1));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; clk_en = 1'b1; i_valid = 1'b0; i_sof = 1'b0; i_real = '0; i_imag = '0;
    repeat (3) step();
    check_value("rst_valid", int'(o_valid), 0);
    check_value("rst_sof",   int'(o_sof), 0);
    check_value("rst_eof",   int'(o_eof), 0);
    check_value("rst_err",   int'(o_frame_err), 0);
    check_value("rst_re",    int'(o_real), 0);
    check_value("rst_im",    int'(o_imag), 0);
    rst = 1'b0;
    step();

    // Single frame, latency and order.
    outq.delete();
    send_frame(1'b0);
    wait_outputs(N, 40);
    repeat (6) step();
    check_frames("s1", N);
    if (outq.size() > 0) check_value("s1_latency", outq[0].ecnt - last_wr_ecnt, 3);

    // Two back-to-back frames stream out without a gap.
    outq.delete();
    send_frame(1'b0);
    send_frame(1'b0);
    wait_outputs(2 * N, 60);
    repeat (6) step();
    check_frames("s2", 2 * N);
    for (int i = 1; i < outq.size(); i++) begin
      check_value("s2_gap", outq[i].ecnt - outq[i-1].ecnt, 1);
    end

    // Input gaps plus a clk_en stall mid-readout while bin 3 is on the output.
    outq.delete();
    send_frame(1'b1);
    wait_outputs(3, 40);
    clk_en = 1'b0;
    repeat (3) begin
      step();
      check_value("s3_hold_valid", int'(o_valid), 1);
      check_value("s3_hold_re", int'(o_real), 3);
      check_value("s3_hold_im", int'(o_imag), -3);
    end
    clk_en = 1'b1;
    wait_outputs(N, 40);
    repeat (6) step();
    check_frames("s3", N);

    // Premature i_sof at sample 5, then the restarted frame completes.
    outq.delete();
    err_cnt = 0;
    for (int j = 0; j < 5; j++) send(j == 0, 100 + j, 50 + j);
    check_value("s4_err_before", int'(o_frame_err), 0);
    send(1'b1, tb_bitrev(0), -tb_bitrev(0));
    check_value("s4_err_now", int'(o_frame_err), 1);
    for (int j = 1; j < N; j++) send(1'b0, tb_bitrev(j), -tb_bitrev(j));
    wait_outputs(N, 40);
    repeat (6) step();
    check_value("s4_err_pulses", err_cnt, 1);
    check_frames("s4", N);

    // Samples without i_sof after reset are dropped.
    rst = 1'b1;
    step();
    rst = 1'b0;
    outq.delete();
    for (int j = 0; j < 4; j++) send(1'b0, 7, 7);
    repeat (10) step();
    check_value("s5_nosof_out", outq.size(), 0);

    // Reset during readout at bin 3, then a fresh frame.
    send_frame(1'b0);
    wait_outputs(3, 40);
    check_value("s5_bin3_re", int'(o_real), 3);
    rst = 1'b1;
    step();
    check_value("s5_rst_valid", int'(o_valid), 0);
    rst = 1'b0;
    repeat (10) step();
    check_value("s5_cut_count", outq.size(), 4);
    outq.delete();
    send_frame(1'b0);
    wait_outputs(N, 40);
    repeat (6) step();
    check_frames("s5", N);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
